// File: rtl/rc4_prga_decrypt_if.sv
// Bundles the control handshake and the three memory ports of the RC4 decryptor.
// master = the decryptor; slave = controller plus S-memory, ROM and decrypted RAM.
interface rc4_prga_decrypt_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       key_invalid;
    logic [7:0] s_addr;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] s_rddata;
    logic [7:0] rom_addr;
    logic [7:0] rom_rddata;
    logic [7:0] d_addr;
    logic [7:0] d_wrdata;
    logic       d_wren;

    modport master (
        input  start, s_rddata, rom_rddata,
        output busy, done, key_invalid,
               s_addr, s_wrdata, s_wren, rom_addr, d_addr, d_wrdata, d_wren
    );

    modport slave (
        output start, s_rddata, rom_rddata,
        input  busy, done, key_invalid,
               s_addr, s_wrdata, s_wren, rom_addr, d_addr, d_wrdata, d_wren
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator: swaps S entries, XORs keystream with ROM bytes, writes plaintext.
// 9 cycles per byte plus one DONE cycle; no backpressure, memories assumed 1-cycle read latency.
module rc4_prga_decrypt #(
    parameter int MSG_LEN     = 32,
    parameter bit CHECK_ASCII = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    rc4_prga_decrypt_if.master   bus
);

    localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, RD_F, GET_F, WR_D, DONE
    } state_t;

    state_t     state, state_next;
    logic [7:0] i, j, k;
    logic [7:0] si, sj, f, e;
    logic       key_invalid_q;
    logic       busy_q;
    logic [7:0] plain;
    logic       plain_ok;

    assign plain    = f ^ e;
    assign plain_ok = (plain == 8'd32) || (plain >= 8'd97 && plain <= 8'd122);

    always_comb begin
        state_next       = state;
        bus.busy         = busy_q;
        bus.key_invalid  = key_invalid_q;
        bus.done         = 1'b0;
        bus.s_addr       = 8'd0;
        bus.s_wrdata     = 8'd0;
        bus.s_wren       = 1'b0;
        bus.rom_addr     = 8'd0;
        bus.d_addr       = 8'd0;
        bus.d_wrdata     = 8'd0;
        bus.d_wren       = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_next = RD_I;
            RD_I:  begin bus.s_addr = i; state_next = GET_I; end
            GET_I: state_next = RD_J;
            RD_J:  begin bus.s_addr = j; state_next = GET_J; end
            GET_J: state_next = WR_I;
            WR_I: begin
                bus.s_addr   = i;
                bus.s_wrdata = sj;
                bus.s_wren   = 1'b1;
                state_next   = WR_J;
            end
            WR_J: begin
                bus.s_addr   = j;
                bus.s_wrdata = si;
                bus.s_wren   = 1'b1;
                state_next   = RD_F;
            end
            // Reads after both swap writes, so the keystream index sees the updated S.
            RD_F: begin
                bus.s_addr   = si + sj;
                bus.rom_addr = k;
                state_next   = GET_F;
            end
            GET_F: state_next = WR_D;
            WR_D: begin
                bus.d_addr   = k;
                bus.d_wrdata = plain;
                bus.d_wren   = 1'b1;
                if (CHECK_ASCII && !plain_ok)
                    state_next = DONE;
                else if (k == K_LAST)
                    state_next = DONE;
                else
                    state_next = RD_I;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            i             <= 8'd0;
            j             <= 8'd0;
            k             <= 8'd0;
            si            <= 8'd0;
            sj            <= 8'd0;
            f             <= 8'd0;
            e             <= 8'd0;
            key_invalid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state  <= state_next;
            // busy rises one cycle after acceptance and holds through DONE.
            busy_q <= (state != IDLE) && (state_next != IDLE);
            case (state)
                IDLE: if (bus.start) begin
                    i             <= 8'd1;
                    j             <= 8'd0;
                    k             <= 8'd0;
                    key_invalid_q <= 1'b0;
                end
                GET_I: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                GET_J: sj <= bus.s_rddata;
                GET_F: begin
                    f <= bus.s_rddata;
                    e <= bus.rom_rddata;
                end
                WR_D: begin
                    if (CHECK_ASCII && !plain_ok) begin
                        key_invalid_q <= 1'b1;
                    end else if (k != K_LAST) begin
                        k <= k + 8'd1;
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: five parameterisations share one clock, each with its own
// S-memory, ROM and decrypted-RAM models, checked against a plain RC4 PRGA reference.
module tb_rc4_prga_decrypt;

    localparam int N = 5;
    localparam int LENS [N] = '{3, 32, 1, 32, 256};
    localparam bit CHKS [N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst [N];
    logic       start [N];
    logic       load [N];
    logic       busy_w [N], done_w [N], kinv_w [N], s_wren_w [N], d_wren_w [N];
    logic [7:0] s_addr_w [N], s_wrdata_w [N], rom_addr_w [N], d_addr_w [N], d_wrdata_w [N];
    logic [7:0] s_rd [N], rom_rd [N];

    logic [7:0] smem  [N][256];
    logic [7:0] dmem  [N][256];
    logic [7:0] rom   [N][256];
    logic [7:0] s_img [N][256];

    for (genvar g = 0; g < N; g++) begin : gen_dut
        rc4_prga_decrypt_if bus ();
        rc4_prga_decrypt #(.MSG_LEN(LENS[g]), .CHECK_ASCII(CHKS[g])) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus.master)
        );
        assign bus.start      = start[g];
        assign bus.s_rddata   = s_rd[g];
        assign bus.rom_rddata = rom_rd[g];
        assign busy_w[g]      = bus.busy;
        assign done_w[g]      = bus.done;
        assign kinv_w[g]      = bus.key_invalid;
        assign s_wren_w[g]    = bus.s_wren;
        assign d_wren_w[g]    = bus.d_wren;
        assign s_addr_w[g]    = bus.s_addr;
        assign s_wrdata_w[g]  = bus.s_wrdata;
        assign rom_addr_w[g]  = bus.rom_addr;
        assign d_addr_w[g]    = bus.d_addr;
        assign d_wrdata_w[g]  = bus.d_wrdata;
    end

    // Synchronous memories with one-cycle read latency; load copies the S image and blanks dmem.
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (load[g]) begin
                for (int a = 0; a < 256; a++) begin
                    smem[g][a] <= s_img[g][a];
                    dmem[g][a] <= 8'hEE;
                end
            end else begin
                if (s_wren_w[g]) smem[g][s_addr_w[g]] <= s_wrdata_w[g];
                if (d_wren_w[g]) dmem[g][d_addr_w[g]] <= d_wrdata_w[g];
            end
            s_rd[g]   <= smem[g][s_addr_w[g]];
            rom_rd[g] <= rom[g][rom_addr_w[g]];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int g);
        return {19'd0, busy_w[g], done_w[g], kinv_w[g], s_wren_w[g], d_wren_w[g],
                s_addr_w[g], s_wrdata_w[g], rom_addr_w[g], d_addr_w[g], d_wrdata_w[g]};
    endfunction

    function automatic bit is_text(input logic [7:0] b);
        return (b == 8'd32) || (b >= 8'd97 && b <= 8'd122);
    endfunction

    // Reference RC4 PRGA on a private copy of S.
    logic [7:0] m_s [256];
    logic [7:0] m_out [256];
    int         m_n;
    bit         m_inv;

    task automatic model(input int g, input bit use_chk);
        int i, j;
        logic [7:0] t;
        i = 0; j = 0; m_n = 0; m_inv = 0;
        for (int a = 0; a < 256; a++) m_s[a] = s_img[g][a];
        for (int k = 0; k < LENS[g]; k++) begin
            i = (i + 1) % 256;
            j = (j + m_s[i]) % 256;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            m_out[k] = m_s[(m_s[i] + m_s[j]) % 256] ^ rom[g][k];
            m_n++;
            if (use_chk && !is_text(m_out[k])) begin
                m_inv = 1;
                break;
            end
        end
    endtask

    task automatic set_identity(input int g);
        for (int a = 0; a < 256; a++) s_img[g][a] = 8'(a);
    endtask

    task automatic set_random_perm(input int g);
        logic [7:0] t;
        int r;
        set_identity(g);
        for (int a = 255; a > 0; a--) begin
            r = $urandom_range(a, 0);
            t = s_img[g][a]; s_img[g][a] = s_img[g][r]; s_img[g][r] = t;
        end
    endtask

    task automatic set_rom(input int g, input bit rnd);
        for (int a = 0; a < 256; a++) rom[g][a] = rnd ? 8'($urandom) : 8'h00;
    endtask

    // ROM chosen so the plaintext is all lowercase/space under the current S image.
    task automatic set_text_rom(input int g);
        logic [7:0] c;
        set_rom(g, 1'b0);
        model(g, 1'b0);
        for (int k = 0; k < LENS[g]; k++) begin
            c = ($urandom_range(26, 0) == 26) ? 8'd32 : 8'(97 + $urandom_range(25, 0));
            rom[g][k] = m_out[k] ^ c;
        end
    endtask

    task automatic load_mem(input int g);
        @(negedge clk) load[g] = 1'b1;
        @(negedge clk) load[g] = 1'b0;
    endtask

    int r_done_cyc, r_ndone, r_busy_lo, r_busy_hi, r_busy_cnt, r_nsw, r_ndw, r_kinv_first;
    logic r_kinv0, r_kinv_end;
    bit r_timeout;

    // Cycle c = the cycle following edge c, where edge 0 accepts start.
    task automatic run(input int g, input int extra_at);
        int c;
        int budget;
        budget = 9 * LENS[g] + 20;
        r_done_cyc = -1; r_ndone = 0; r_busy_lo = -1; r_busy_hi = -1; r_busy_cnt = 0;
        r_nsw = 0; r_ndw = 0; r_kinv_first = -1; r_kinv0 = 1'bx; r_kinv_end = 1'bx;
        r_timeout = 0;
        @(negedge clk) start[g] = 1'b1;
        @(posedge clk);
        c = 0;
        forever begin
            @(negedge clk);
            start[g] = (c == extra_at);
            if (busy_w[g]) begin
                r_busy_cnt++;
                if (r_busy_lo < 0) r_busy_lo = c;
                r_busy_hi = c;
            end
            if (done_w[g]) begin r_ndone++; r_done_cyc = c; end
            if (s_wren_w[g]) r_nsw++;
            if (d_wren_w[g]) r_ndw++;
            if (c == 0) r_kinv0 = kinv_w[g];
            if (kinv_w[g] && r_kinv_first < 0) r_kinv_first = c;
            r_kinv_end = kinv_w[g];
            if (r_ndone > 0 && c >= r_done_cyc + 3) break;
            if (c >= budget) begin r_timeout = 1; break; end
            c++;
        end
        start[g] = 1'b0;
    endtask

    task automatic verify(input int g, input string nm);
        int dm, sm;
        model(g, CHKS[g]);
        check({nm, ".timeout"},  r_timeout,  0);
        check({nm, ".ndone"},    r_ndone,    1);
        check({nm, ".done_cyc"}, r_done_cyc, 9 * m_n);
        check({nm, ".busy_lo"},  r_busy_lo,  1);
        check({nm, ".busy_hi"},  r_busy_hi,  9 * m_n);
        check({nm, ".busy_cnt"}, r_busy_cnt, 9 * m_n);
        check({nm, ".n_dwr"},    r_ndw,      m_n);
        check({nm, ".n_swr"},    r_nsw,      2 * m_n);
        check({nm, ".kinv"},     r_kinv_end, m_inv);
        dm = 0; sm = 0;
        for (int k = 0; k < m_n; k++) if (dmem[g][k] !== m_out[k]) dm++;
        if (m_n < 256 && dmem[g][m_n] !== 8'hEE) dm++;
        for (int a = 0; a < 256; a++) if (smem[g][a] !== m_s[a]) sm++;
        check({nm, ".dmem_bad"}, dm, 0);
        check({nm, ".smem_bad"}, sm, 0);
    endtask

    initial begin
        int w;
        for (int g = 0; g < N; g++) begin
            rst[g] = 1'b1; start[g] = 1'b0; load[g] = 1'b0;
            set_identity(g);
            set_rom(g, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) check($sformatf("reset_outs%0d", g), outs(g), 0);
        for (int g = 0; g < N; g++) rst[g] = 1'b0;

        // Known-answer run on identity S.
        set_identity(0); set_rom(0, 1'b0); load_mem(0);
        run(0, -1);
        verify(0, "kat3");
        check("kat3.d0", dmem[0][0], 8'h02);
        check("kat3.d1", dmem[0][1], 8'h05);
        check("kat3.d2", dmem[0][2], 8'h07);
        check("kat3.s2", smem[0][2], 8'd3);
        check("kat3.s3", smem[0][3], 8'd5);
        check("kat3.s5", smem[0][5], 8'd2);

        // 32-byte timing with a stray start while busy, then one during DONE.
        set_identity(1); set_rom(1, 1'b1); load_mem(1);
        run(1, 5);
        verify(1, "len32_busystart");
        check("len32.done_at_288", r_done_cyc, 288);
        set_random_perm(1); set_rom(1, 1'b1); load_mem(1);
        run(1, 288);
        verify(1, "len32_donestart");

        // Single-byte text check that passes.
        set_identity(2); set_rom(2, 1'b0); rom[2][0] = 8'h63; load_mem(2);
        run(2, -1);
        verify(2, "ascii_pass");
        check("ascii_pass.d0", dmem[2][0], 8'h61);
        check("ascii_pass.kinv", r_kinv_end, 1'b0);

        // Early abort on first byte, then a valid run must clear the sticky flag.
        set_identity(3); set_rom(3, 1'b0); load_mem(3);
        run(3, -1);
        verify(3, "ascii_abort");
        check("ascii_abort.d0", dmem[3][0], 8'h02);
        check("ascii_abort.kinv_first", r_kinv_first, 9);
        check("ascii_abort.kinv_sticky", r_kinv_end, 1'b1);
        set_random_perm(3); set_text_rom(3); load_mem(3);
        run(3, -1);
        verify(3, "ascii_clear");
        check("ascii_clear.kinv0", r_kinv0, 1'b0);

        // Reset in the cycle after the first S write.
        set_identity(1); set_rom(1, 1'b0); load_mem(1);
        @(negedge clk) start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk) start[1] = 1'b0;
        w = 0;
        while (!s_wren_w[1] && w < 20) begin @(negedge clk); w++; end
        check("midreset.wait_swren", (w < 20), 1'b1);
        @(posedge clk); #1 rst[1] = 1'b1;
        @(negedge clk);
        check("midreset.outs", outs(1), 0);
        @(negedge clk) rst[1] = 1'b0;
        set_random_perm(1); set_rom(1, 1'b1); load_mem(1);
        run(1, -1);
        verify(1, "after_reset");

        // Full 256-byte run: i wraps, addresses reach 255.
        set_identity(4); set_rom(4, 1'b1); load_mem(4);
        run(4, -1);
        verify(4, "wrap256");
        check("wrap256.done_at_2304", r_done_cyc, 2304);
        set_random_perm(4); set_rom(4, 1'b1); load_mem(4);
        run(4, -1);
        verify(4, "wrap256_rand");

        // Randomised runs across the shorter configurations.
        for (int it = 0; it < 4; it++) begin
            set_random_perm(0); set_rom(0, 1'b1); load_mem(0);
            run(0, -1); verify(0, $sformatf("rnd0_%0d", it));
            set_random_perm(2); set_rom(2, 1'b1); load_mem(2);
            run(2, -1); verify(2, $sformatf("rnd2_%0d", it));
            set_random_perm(3);
            if (it % 2 == 0) set_text_rom(3); else set_rom(3, 1'b1);
            load_mem(3);
            run(3, -1); verify(3, $sformatf("rnd3_%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
RC4 keystream generator and decryptor. It runs after the S-memory init and key-schedule FSMs have filled and shuffled S[0..255], and it is the read-side consumer of that array. It reads and swaps S entries, generates one keystream byte per message byte, XORs it with the encrypted ROM byte, and writes the plaintext to the decrypted RAM. An optional ASCII check flags a wrong key early, for key-search loops.

Parameters:
MSG_LEN, 32, number of message bytes processed per run (1..256).
CHECK_ASCII, 1, 1 = abort the run on the first decrypted byte outside {32, 97..122}; 0 = no check.

Ports:
clk  in  1  system clock (CLK_50M domain).
reset  in  1  asynchronous, active-high.
start  in  1  single-cycle request; sampled only in IDLE.
busy  out  1  high from the cycle after start is accepted until DONE exits.
done  out  1  one-cycle pulse in DONE.
key_invalid  out  1  sticky ASCII-failure flag; cleared when start is accepted.
s_addr  out  8  S-memory address.
s_wrdata  out  8  S-memory write data.
s_wren  out  1  S-memory write enable.
s_rddata  in  8  S-memory read data; valid the cycle after s_addr is driven.
rom_addr  out  8  encrypted ROM address (k).
rom_rddata  in  8  ROM data; same 1-cycle latency.
d_addr  out  8  decrypted RAM address (k).
d_wrdata  out  8  plaintext byte.
d_wren  out  1  decrypted RAM write enable.

Behaviour:
- Reset: FSM goes to IDLE; i=j=k=0; si, sj and f are cleared. All outputs are 0 (busy, done, key_invalid, all addr/data, s_wren, d_wren).
- Write enables: s_wren and d_wren are high only in the write states. Both are 0 in IDLE, so the upstream mux can hand S-memory to this block unconditionally.
- Arithmetic: all index arithmetic is 8-bit modulo 256; carries are dropped.
- IDLE: on start, set i=1, j=0, k=0, key_invalid=0, then go to RD_I.
- RD_I: s_addr=i. Next state is GET_I.
- GET_I: si<=s_rddata; j<=j+s_rddata. Next state is RD_J.
- RD_J: s_addr=j. Next state is GET_J.
- GET_J: sj<=s_rddata. Next state is WR_I.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1. Next state is WR_J.
- WR_J: s_addr=j, s_wrdata=si, s_wren=1. Next state is RD_F.
- RD_F: s_addr=si+sj; rom_addr=k. Next state is GET_F.
- GET_F: f<=s_rddata; e<=rom_rddata. Next state is WR_D.
- WR_D: d_addr=k, d_wrdata=f^e, d_wren=1.
  - If CHECK_ASCII and the byte is not in {32, 97..122}: key_invalid<=1, go to DONE.
  - Else if k==MSG_LEN-1: go to DONE.
  - Else: k<=k+1, i<=i+1, go to RD_I.
- DONE: done=1 for one cycle; go to IDLE.
- Timing:
  - 9 cycles per byte.
  - With start accepted at edge 0, DONE is occupied during cycle 9*MSG_LEN (cycle 9*(k+1) on an early abort).
  - busy is high in cycles 1..9*MSG_LEN inclusive, i.e. through the DONE cycle.
- i==j: both writes carry the same value (si==sj), so S is unchanged. No special case is needed.
- The f read happens after both swap writes, so it sees the updated S, as the algorithm requires.
- The invalid byte is still written to the decrypted RAM before the abort.
- start is ignored outside IDLE, including during DONE.
- Reset mid-run: immediate return to IDLE with enables low. Partially written S and decrypted RAM contents are not restored.

Test Plan:
- Byte values (MSG_LEN=3, CHECK_ASCII=0): S preloaded with identity (S[x]=x), ROM all 0x00, start pulse -> d writes 0x02@0, 0x05@1, 0x07@2. Final S[2]=3, S[3]=5, S[5]=2. done pulses once; key_invalid=0.
- Timing (MSG_LEN=32, CHECK_ASCII=0): start at edge 0 -> done high exactly in cycle 288; busy high in cycles 1..288; 32 d_wren pulses; 64 s_wren pulses.
- ASCII pass (CHECK_ASCII=1, MSG_LEN=1): identity S, ROM[0]=0x63 -> d_wrdata 0x61 ('a'); key_invalid=0; done in cycle 9.
- ASCII abort (CHECK_ASCII=1, MSG_LEN=32): identity S, ROM all 0x00 -> only address 0 written (0x02); key_invalid=1 in cycle 9 and stays 1. A following start clears it.
- Protocol: second start pulse while busy -> ignored; exactly one done pulse. Reset asserted in the cycle after the first s_wren -> all outputs 0 next cycle, FSM in IDLE; a fresh start runs normally.
- Wrap (MSG_LEN=256, CHECK_ASCII=0): i wraps 255->0 on the last byte; done in cycle 2304; rom_addr/d_addr reach 255 with no overflow write.
